// File: rtl/acc_cpu_core.sv
// acc_cpu_core -- two-word accumulator CPU core with a req/ack memory port.
//
// Every instruction is an opcode word followed by an operand word. The
// controller walks IDLE -> FOP -> FARG -> EXEC -> [MEM] -> FOP. HALT is
// terminal until reset. Any wait states the memory adds stretch the
// requesting state.
//
// Build option: define ACC_CPU_CALL_STACK_EN to add a STACK_DEPTH-entry
// hardware return-address stack for CALL (0x0B) and RET (0x0C). When it is
// undefined, those two codes decode as illegal opcodes.
//
// Memory handshake: mem_req is high for the whole of FOP, FARG and MEM.
// mem_addr, mem_we and mem_wdata are functions of registered state only, so
// they hold steady while mem_req=1 and mem_ack=0. The transfer completes on
// the rising edge where mem_req=1 and mem_ack=1; mem_rdata is sampled on that
// edge. mem_ack is ignored whenever mem_req=0.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   mem_req/we/addr/wdata   request side of the memory port (wdata = ac)
//   mem_rdata, mem_ack      response side of the memory port
//   pc, ac                  program counter, accumulator
//   ir_opcode, ir_operand   upper (opcode) and lower (operand) instruction words
//   state                   FSM state code (0 IDLE .. 5 HALT)
//   zflg, nflg              ac == 0, ac sign bit
//   halted, fault           core stopped / stopped because of an error
module acc_cpu_core #(
   parameter int DW          = 8,
   parameter int AW          = 8,
   parameter int STACK_DEPTH = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ack,
   output logic [AW-1:0] pc,
   output logic [DW-1:0] ac,
   output logic [DW-1:0] ir_opcode,
   output logic [DW-1:0] ir_operand,
   output logic [2:0]    state,
   output logic          zflg,
   output logic          nflg,
   output logic          halted,
   output logic          fault
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_FOP  = 3'd1,
      S_FARG = 3'd2,
      S_EXEC = 3'd3,
      S_MEM  = 3'd4,
      S_HALT = 3'd5
   } state_t;

   localparam logic [4:0] OP_NOP  = 5'h00;
   localparam logic [4:0] OP_LDI  = 5'h01;
   localparam logic [4:0] OP_LDA  = 5'h02;
   localparam logic [4:0] OP_STA  = 5'h03;
   localparam logic [4:0] OP_ADD  = 5'h04;
   localparam logic [4:0] OP_SUB  = 5'h05;
   localparam logic [4:0] OP_AND  = 5'h06;
   localparam logic [4:0] OP_JMP  = 5'h07;
   localparam logic [4:0] OP_JZ   = 5'h08;
   localparam logic [4:0] OP_JN   = 5'h09;
   localparam logic [4:0] OP_ADDI = 5'h0A;
`ifdef ACC_CPU_CALL_STACK_EN
   localparam logic [4:0] OP_CALL = 5'h0B;
   localparam logic [4:0] OP_RET  = 5'h0C;
`endif
   localparam logic [4:0] OP_HALT = 5'h1F;

   // Parameter sanity: the legal space is DW >= 8, AW <= DW, STACK_DEPTH >= 1.
   // Nothing is built here; an out-of-range set simply elaborates this empty
   // block and is caught by review of the instantiating top.
   if (DW < 8 || AW > DW || STACK_DEPTH < 1) begin : g_param_out_of_range
   end

   state_t        cur_state;
   state_t        nxt_state;
   logic [4:0]    opc;
   logic [AW-1:0] arg_addr;
   logic          ld_iru;
   logic          ld_irl;
   logic          pc_inc;
   logic          pc_ld;
   logic [AW-1:0] pc_val;
   logic          ac_ld;
   logic [DW-1:0] ac_val;
   logic          fault_set;

   assign opc      = ir_opcode[4:0];
   assign arg_addr = ir_operand[AW-1:0];

`ifdef ACC_CPU_CALL_STACK_EN
   localparam int SP_W = $clog2(STACK_DEPTH + 1);
   localparam int IX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   logic [AW-1:0]   stack_mem [STACK_DEPTH];
   logic [SP_W-1:0] sp;
   logic            push;
   logic            pop;
   logic            stack_full;
   logic            stack_empty;
   logic [IX_W-1:0] push_idx;
   logic [IX_W-1:0] top_idx;

   assign stack_full  = (sp == SP_W'(STACK_DEPTH));
   assign stack_empty = (sp == '0);
   assign push_idx    = IX_W'(sp);
   assign top_idx     = IX_W'(sp - SP_W'(1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sp <= '0;
      end else if (push) begin
         sp <= sp + SP_W'(1);
      end else if (pop) begin
         sp <= sp - SP_W'(1);
      end
   end

   // Entries above sp are don't-care, so the storage itself needs no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         stack_mem[push_idx] <= pc;
      end
   end
`endif

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cur_state <= S_IDLE;
      end else begin
         cur_state <= nxt_state;
      end
   end

   // Next-state, memory port and datapath controls.
   always_comb begin
      nxt_state = cur_state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = pc;
      ld_iru    = 1'b0;
      ld_irl    = 1'b0;
      pc_inc    = 1'b0;
      pc_ld     = 1'b0;
      pc_val    = arg_addr;
      ac_ld     = 1'b0;
      ac_val    = ac;
      fault_set = 1'b0;
`ifdef ACC_CPU_CALL_STACK_EN
      push      = 1'b0;
      pop       = 1'b0;
`endif
      case (cur_state)
         S_IDLE: nxt_state = S_FOP;
         S_FOP: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ld_iru    = 1'b1;
               pc_inc    = 1'b1;
               nxt_state = S_FARG;
            end
         end
         S_FARG: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               ld_irl    = 1'b1;
               pc_inc    = 1'b1;
               nxt_state = S_EXEC;
            end
         end
         S_EXEC: begin
            nxt_state = S_FOP;
            case (opc)
               OP_NOP: ;
               OP_LDI: begin
                  ac_ld  = 1'b1;
                  ac_val = ir_operand;
               end
               OP_ADDI: begin
                  ac_ld  = 1'b1;
                  ac_val = ac + ir_operand;
               end
               OP_JMP: pc_ld = 1'b1;
               OP_JZ:  pc_ld = zflg;
               OP_JN:  pc_ld = nflg;
               OP_LDA, OP_STA, OP_ADD, OP_SUB, OP_AND: nxt_state = S_MEM;
               OP_HALT: nxt_state = S_HALT;
`ifdef ACC_CPU_CALL_STACK_EN
               // pc already points past the operand word, so it is the
               // return address as-is.
               OP_CALL: begin
                  if (stack_full) begin
                     fault_set = 1'b1;
                     nxt_state = S_HALT;
                  end else begin
                     push  = 1'b1;
                     pc_ld = 1'b1;
                  end
               end
               OP_RET: begin
                  if (stack_empty) begin
                     fault_set = 1'b1;
                     nxt_state = S_HALT;
                  end else begin
                     pop    = 1'b1;
                     pc_ld  = 1'b1;
                     pc_val = stack_mem[top_idx];
                  end
               end
`endif
               default: begin
                  fault_set = 1'b1;
                  nxt_state = S_HALT;
               end
            endcase
         end
         S_MEM: begin
            mem_req  = 1'b1;
            mem_addr = arg_addr;
            mem_we   = (opc == OP_STA);
            if (mem_ack) begin
               nxt_state = S_FOP;
               case (opc)
                  OP_LDA: begin
                     ac_ld  = 1'b1;
                     ac_val = mem_rdata;
                  end
                  OP_ADD: begin
                     ac_ld  = 1'b1;
                     ac_val = ac + mem_rdata;
                  end
                  OP_SUB: begin
                     ac_ld  = 1'b1;
                     ac_val = ac - mem_rdata;
                  end
                  OP_AND: begin
                     ac_ld  = 1'b1;
                     ac_val = ac & mem_rdata;
                  end
                  default: ;
               endcase
            end
         end
         S_HALT: nxt_state = S_HALT;
         default: nxt_state = S_IDLE;
      endcase
   end

   // Architectural registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc         <= '0;
         ac         <= '0;
         ir_opcode  <= '0;
         ir_operand <= '0;
         fault      <= 1'b0;
      end else begin
         if (ld_iru) begin
            ir_opcode <= mem_rdata;
         end
         if (ld_irl) begin
            ir_operand <= mem_rdata;
         end
         if (pc_ld) begin
            pc <= pc_val;
         end else if (pc_inc) begin
            pc <= pc + AW'(1);
         end
         if (ac_ld) begin
            ac <= ac_val;
         end
         if (fault_set) begin
            fault <= 1'b1;
         end
      end
   end

   assign state     = cur_state;
   assign halted    = (cur_state == S_HALT);
   assign mem_wdata = ac;
   assign zflg      = (ac == '0);
   assign nflg      = ac[DW-1];

endmodule
